display_share_arbiter: RTL and testbench
========================================

// Module: display_share_arbiter
// PURPOSE
//  Shares the single 4-digit seven-segment display between up to N_REQ value sources
//  (free-running counter, debug registers, status words).
//  Grants the display to one requester at a time, round-robin, for a fixed dwell time.
//  Drives the 16-bit value bus feeding the display4digit driver.
//  Sits between the value producers and display4digit in the top level.
// PARAMETERS
//  N_REQ        4            number of requesters, 2..8
//  VAL_W        16           value width, 4 hex digits
//  DWELL_CYCLES 100_000_000  clk cycles per display slot, >=2 (1 s at 100 MHz)
// PORTS
//  clk        in   1            system clock, all logic on rising edge
//  rst_n      in   1            asynchronous active-low reset
//  req        in   N_REQ        level request per source, held while it wants the display
//  data       in   N_REQ*VAL_W  source values, source i at [i*VAL_W +: VAL_W]
//  gnt        out  N_REQ        one-hot, registered; bit i high while source i owns display
//  owner      out  $clog2(N_REQ) index of current owner, valid when active=1
//  active     out  1            a source owns the display
//  value      out  VAL_W        value presented to display4digit
// BEHAVIOUR
//  Reset: state=IDLE, gnt=0, owner=0, active=0, value=0, dwell=0, rr pointer=N_REQ-1.
//  State IDLE
//   - value holds its last content.
//   - If any req is sampled at edge t: winner = first set req scanning from rr_ptr+1 upward, wrapping.
//   - At edge t: gnt[winner]=1, owner=winner, active=1, value=data[winner], dwell=DWELL_CYCLES-1.
//   - rr_ptr=winner; next state SHOW (one-cycle request-to-grant latency).
//  State SHOW
//   - Each cycle with req[owner]=1: value <= data[owner] (live tracking); dwell decrements.
//   - Owner drops req: slot ends at that edge, then arbitration.
//   - dwell reaches 0: slot ends, then arbitration.
//  Arbitration at slot end, decided combinationally, registered at the same edge:
//   - Another requester pending: switch to the next RR winner, excluding the owner.
//   - Only the owner pending: owner keeps the display, dwell reloads, no gnt glitch.
//   - Nothing pending: IDLE, gnt=0, active=0, value frozen at its last shown value.
//  Constraints
//   - Data changes of non-owners are ignored.
//   - gnt is never multi-hot; dwell counter width is $clog2(DWELL_CYCLES).
//   - Simultaneous slot expiry and owner req drop: treated as expiry, owner not re-granted.
//   - rst_n assertion mid-slot clears everything immediately (async); after deassertion
//     the first grant behaves as from reset.
// CONFIGURATION
//  DISPLAY_ARB_PREEMPT_EN
//   - Defined: source 0 is priority. req[0] rising while another source owns the display
//     ends that slot at the next edge and grants source 0; rr_ptr is unchanged by a
//     preemptive grant.
//   - Undefined: pure round-robin, source 0 has no special rights.
// STRUCTURE
//  Package display_arb_pkg: typedef enum logic {IDLE, SHOW} arb_state_t;
//   localparam VAL_W_DEFAULT=16, N_REQ_MAX=8.
//  Sub-module rr_picker: combinational; inputs req vector, rr_ptr, exclude mask;
//   outputs winner index and found flag. Instantiated once.
// TESTING (DWELL_CYCLES=4 for simulation)
//  1. Reset, req=0001, data0=16'h1234 -> gnt=0001 and value=1234 one cycle later; active=1.
//  2. req=1111 held -> owners cycle 0,1,2,3,0 every 4 clks; gnt always one-hot.
//  3. Owner 2 only, data2 counting -> value follows data2 each cycle; dwell reloads, gnt stays 0100.
//  4. Owner 1 drops req mid-slot with no others pending -> IDLE next edge, gnt=0, value frozen.
//  5. rst_n low for 1 ns mid-SHOW -> gnt=0, value=0 asynchronously; req=0010 then grants source 1.
//  6. Macro defined, owner 3 in slot, req[0] rises -> gnt=0001 next edge; without macro, grant
//     to source 0 only at slot end.

Source files
------------

// File: rtl/display_arb_pkg.sv
// Shared types and defaults for the display share arbiter.
package display_arb_pkg;

  typedef enum logic {IDLE, SHOW} arb_state_t;

  localparam int VAL_W_DEFAULT = 16;
  localparam int N_REQ_MAX     = 8;

endpackage

// File: rtl/display_share_arbiter_rr_picker.sv
// Round-robin picker: first candidate strictly after rr_ptr, wrapping, skipping excluded bits.
module rr_picker
  import display_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] rr_ptr,
  input  logic [N_REQ-1:0] exclude,
  output logic [IDX_W-1:0] winner,
  output logic             found
);

  logic [N_REQ-1:0] cand_s;
  int               pos_s;

  // Scan from the farthest offset down so the nearest candidate is written last.
  always_comb begin
    cand_s = req & ~exclude;
    found  = |cand_s;
    winner = '0;
    pos_s  = 32'sd0;
    for (int k = N_REQ; k >= 1; k--) begin
      pos_s  = (int'(rr_ptr) + k) % N_REQ;
      winner = cand_s[pos_s] ? IDX_W'(pos_s) : winner;
    end
  end

endmodule

// File: rtl/display_share_arbiter.sv
// Round-robin sharing of the 4-digit display between value sources, fixed dwell per slot.
// Optional source-0 preemption is enabled by defining DISPLAY_ARB_PREEMPT_EN.
module display_share_arbiter
  import display_arb_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int VAL_W        = VAL_W_DEFAULT,
  parameter int DWELL_CYCLES = 100_000_000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*VAL_W-1:0]   data,
  output logic [N_REQ-1:0]         gnt,
  output logic [$clog2(N_REQ)-1:0] owner,
  output logic                     active,
  output logic [VAL_W-1:0]         value
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int DW_W  = $clog2(DWELL_CYCLES);
  localparam logic [DW_W-1:0]  DWELL_LOAD = DW_W'(DWELL_CYCLES - 1);
  localparam logic [IDX_W-1:0] PTR_RESET  = IDX_W'(N_REQ - 1);

  arb_state_t       state_r, state_nxt_s;
  logic [N_REQ-1:0] gnt_r, gnt_nxt_s;
  logic [IDX_W-1:0] owner_r, owner_nxt_s;
  logic             active_r, active_nxt_s;
  logic [VAL_W-1:0] value_r, value_nxt_s;
  logic [DW_W-1:0]  dwell_r, dwell_nxt_s;
  logic [IDX_W-1:0] rr_ptr_r, rr_ptr_nxt_s;

  logic [IDX_W-1:0] winner_s;
  logic             found_s;
  logic             own_req_s;
  logic             preempt_s;
  logic [VAL_W-1:0] owner_data_s, winner_data_s;

  // The current owner is excluded so a slot end always moves on when anyone else waits.
  rr_picker #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_picker (
    .req     (req),
    .rr_ptr  (rr_ptr_r),
    .exclude (gnt_r),
    .winner  (winner_s),
    .found   (found_s)
  );

  assign own_req_s     = req[owner_r];
  assign owner_data_s  = data[int'(owner_r)*VAL_W +: VAL_W];
  assign winner_data_s = data[int'(winner_s)*VAL_W +: VAL_W];

`ifdef DISPLAY_ARB_PREEMPT_EN
  logic req0_r;

  // Last sampled req[0], used to spot its rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req0_r <= 1'b0;
    end else begin
      req0_r <= req[0];
    end
  end

  assign preempt_s = (state_r == SHOW) && req[0] && !req0_r && (owner_r != '0);
`else
  assign preempt_s = 1'b0;
`endif

  // Next-state and next-output decision for the slot FSM.
  always_comb begin
    state_nxt_s  = state_r;
    gnt_nxt_s    = gnt_r;
    owner_nxt_s  = owner_r;
    active_nxt_s = active_r;
    value_nxt_s  = value_r;
    dwell_nxt_s  = dwell_r;
    rr_ptr_nxt_s = rr_ptr_r;
    case (state_r)
      IDLE: begin
        if (found_s) begin
          state_nxt_s         = SHOW;
          gnt_nxt_s           = '0;
          gnt_nxt_s[winner_s] = 1'b1;
          owner_nxt_s         = winner_s;
          active_nxt_s        = 1'b1;
          value_nxt_s         = winner_data_s;
          dwell_nxt_s         = DWELL_LOAD;
          rr_ptr_nxt_s        = winner_s;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SHOW: begin
        if (preempt_s) begin
          // Preemptive grant leaves the round-robin pointer where it was.
          gnt_nxt_s    = '0;
          gnt_nxt_s[0] = 1'b1;
          owner_nxt_s  = '0;
          value_nxt_s  = data[VAL_W-1:0];
          dwell_nxt_s  = DWELL_LOAD;
        end else if (own_req_s && (dwell_r != '0)) begin
          value_nxt_s = owner_data_s;
          dwell_nxt_s = dwell_r - 1'b1;
        end else if (found_s) begin
          gnt_nxt_s           = '0;
          gnt_nxt_s[winner_s] = 1'b1;
          owner_nxt_s         = winner_s;
          value_nxt_s         = winner_data_s;
          dwell_nxt_s         = DWELL_LOAD;
          rr_ptr_nxt_s        = winner_s;
        end else if (own_req_s) begin
          value_nxt_s = owner_data_s;
          dwell_nxt_s = DWELL_LOAD;
        end else begin
          state_nxt_s  = IDLE;
          gnt_nxt_s    = '0;
          active_nxt_s = 1'b0;
        end
      end
      default: begin
        state_nxt_s  = IDLE;
        gnt_nxt_s    = '0;
        active_nxt_s = 1'b0;
      end
    endcase
  end

  // Slot FSM state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      gnt_r    <= '0;
      owner_r  <= '0;
      active_r <= 1'b0;
      value_r  <= '0;
      dwell_r  <= '0;
      rr_ptr_r <= PTR_RESET;
    end else begin
      state_r  <= state_nxt_s;
      gnt_r    <= gnt_nxt_s;
      owner_r  <= owner_nxt_s;
      active_r <= active_nxt_s;
      value_r  <= value_nxt_s;
      dwell_r  <= dwell_nxt_s;
      rr_ptr_r <= rr_ptr_nxt_s;
    end
  end

  assign gnt    = gnt_r;
  assign owner  = owner_r;
  assign active = active_r;
  assign value  = value_r;

endmodule

// File: tb/tb_display_share_arbiter.sv
// Self-checking bench for display_share_arbiter (DWELL_CYCLES=4, 4 sources).
module tb_display_share_arbiter;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req = '0;
  logic [N*W-1:0] data = '0;
  logic [N-1:0]  gnt;
  logic [1:0]    owner;
  logic          active;
  logic [W-1:0]  value;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Model: slot owner, cycles used in the current slot, last RR winner.
  int       m_active, m_owner, m_used, m_ptr;
  logic [W-1:0] m_value;
  logic     m_prev0;

  display_share_arbiter #(.N_REQ(N), .VAL_W(W), .DWELL_CYCLES(DW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .data(data),
    .gnt(gnt), .owner(owner), .active(active), .value(value)
  );

  always #5 clk = ~clk;

  function automatic int pick(int start, int excl, logic [N-1:0] r);
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (start + k) % N;
      if (r[i] && i != excl) return i;
    end
    return -1;
  endfunction

  function automatic logic [W-1:0] dsel(int i);
    return data[i*W +: W];
  endfunction

  task automatic model_reset();
    m_active = 0; m_owner = 0; m_used = 0; m_ptr = N - 1; m_value = '0; m_prev0 = 1'b0;
  endtask

  task automatic model_grant(int w);
    m_owner = w; m_active = 1; m_value = dsel(w); m_used = 1;
  endtask

  task automatic model_edge();
    int w;
    bit pre;
    pre = 1'b0;
`ifdef DISPLAY_ARB_PREEMPT_EN
    pre = (m_active != 0) && req[0] && !m_prev0 && (m_owner != 0);
`endif
    if (m_active == 0) begin
      w = pick(m_ptr, -1, req);
      if (w >= 0) begin model_grant(w); m_ptr = w; end
    end else if (pre) begin
      model_grant(0);
    end else if (req[m_owner] && m_used < DW) begin
      m_value = dsel(m_owner);
      m_used++;
    end else begin
      w = pick(m_ptr, m_owner, req);
      if (w >= 0) begin
        model_grant(w); m_ptr = w;
      end else if (req[m_owner]) begin
        m_used = 1; m_value = dsel(m_owner);
      end else begin
        m_active = 0;
      end
    end
    m_prev0 = req[0];
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    logic [N-1:0] eg;
    eg = (m_active != 0) ? (4'b0001 << m_owner) : 4'b0000;
    check("gnt", 32'(gnt), 32'(eg));
    check("active", 32'(active), 32'(m_active));
    if (m_active != 0) check("owner", 32'(owner), 32'(m_owner));
    check("value", 32'(value), 32'(m_value));
  endtask

  always @(negedge clk) begin
    if (cmp_en) compare_model();
  end

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    #1 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_active", 32'(active), 32'h0);
    check("rst_value", 32'(value), 32'h0);
    check("rst_owner", 32'(owner), 32'h0);
    rst_n = 1'b1;
    cmp_en = 1'b1;

    // 1: single requester, one-cycle grant latency, reload with no gnt glitch
    req = 4'b0001; data[15:0] = 16'h1234;
    step();
    check("t1_gnt", 32'(gnt), 32'h1);
    check("t1_value", 32'(value), 32'h1234);
    check("t1_active", 32'(active), 32'h1);
    repeat (4) step();
    check("t1_reload_gnt", 32'(gnt), 32'h1);
    req = 4'b0000;
    step();

    // 2: all requesting, owners rotate every DW cycles
    do_reset();
    req = 4'b1111; data = {16'hD333, 16'hC222, 16'hB111, 16'hA000};
    for (int k = 0; k < 17; k++) begin
      step();
      check("t2_onehot", 32'($onehot(gnt)), 32'h1);
      if (k % 4 == 0) check("t2_owner", 32'(owner), 32'((k / 4) % 4));
    end
    req = 4'b0000;
    step();

    // 3: lone owner 2 with changing data, live tracking across reloads
    do_reset();
    req = 4'b0100;
    for (int i = 0; i < 10; i++) begin
      data[47:32] = 16'h0200 + 16'(i);
      step();
      check("t3_value", 32'(value), 32'h0200 + i);
      check("t3_gnt", 32'(gnt), 32'h4);
    end
    req = 4'b0000;
    step();

    // 4: owner 1 drops mid-slot, nothing pending -> idle with frozen value
    req = 4'b0010; data[31:16] = 16'hABCD;
    step();
    step();
    req = 4'b0000; data[31:16] = 16'hFFFF;
    step();
    check("t4_gnt", 32'(gnt), 32'h0);
    check("t4_active", 32'(active), 32'h0);
    check("t4_value", 32'(value), 32'hABCD);

    // 5: async reset pulse mid-slot, then fresh grant to source 1
    req = 4'b0010; data[31:16] = 16'h5555;
    step();
    step();
    #1 rst_n = 1'b0;
    #1;
    check("t5_rst_gnt", 32'(gnt), 32'h0);
    check("t5_rst_value", 32'(value), 32'h0);
    check("t5_rst_active", 32'(active), 32'h0);
    rst_n = 1'b1;
    model_reset();
    step();
    check("t5_owner", 32'(owner), 32'h1);
    check("t5_gnt", 32'(gnt), 32'h2);
    req = 4'b0000;
    step();

    // 6: source 0 arrives while source 3 owns the display
    do_reset();
    req = 4'b1000; data[63:48] = 16'h3333; data[15:0] = 16'h0AAA;
    step();
    step();
    req = 4'b1001;
    step();
`ifdef DISPLAY_ARB_PREEMPT_EN
    check("t6_preempt_gnt", 32'(gnt), 32'h1);
    check("t6_preempt_value", 32'(value), 32'h0AAA);
    step();
    step();
`else
    check("t6_hold_gnt", 32'(gnt), 32'h8);
    step();
    step();
    check("t6_slotend_gnt", 32'(gnt), 32'h1);
    check("t6_slotend_value", 32'(value), 32'h0AAA);
`endif
    req = 4'b0000;
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
